// File: rtl/toggle_pulse_sync.sv
// toggle_pulse_sync
// Destination half of a toggle pulse synchronizer: resynchronizes a toggle
// level and emits one single-cycle pulse per toggle edge.
// Build option: define TOGGLE_SYNC_CNT_EN to include the pulse counter;
// without it o_pulse_cnt is tied to 0.
module toggle_pulse_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             i_dst_clk,
    input  logic             rst,
    input  logic             i_src_data,
    output logic             o_dst_data,
    output logic             o_dst_level,
    output logic [CNT_W-1:0] o_pulse_cnt
);

    logic [1:0]             rst_sync_q;
    logic                   rst_int;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_last;
    logic                   lvl_q;
    logic                   pulse_d;
    logic                   dst_data_q;

    // Reset assertion passes straight through; release is retimed to i_dst_clk.
    always_ff @(posedge i_dst_clk or posedge rst) begin
        if (rst) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst_int = rst_sync_q[1];

    // Plain flop chain; only sync_q[0] may go metastable, so the chain
    // carries no logic between stages.
    always_ff @(posedge i_dst_clk or posedge rst_int) begin
        if (rst_int) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_src_data};
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign pulse_d   = sync_last ^ lvl_q;

    // Edge detect: both toggle directions produce one registered pulse.
    always_ff @(posedge i_dst_clk or posedge rst_int) begin
        if (rst_int) begin
            lvl_q      <= 1'b0;
            dst_data_q <= 1'b0;
        end else begin
            lvl_q      <= sync_last;
            dst_data_q <= pulse_d;
        end
    end

    assign o_dst_data  = dst_data_q;
    assign o_dst_level = sync_last;

`ifdef TOGGLE_SYNC_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counts on the same edge the pulse register rises; wraps naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (pulse_d) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter register shares the internal reset with the pulse path.
    always_ff @(posedge i_dst_clk or posedge rst_int) begin
        if (rst_int) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_pulse_cnt = cnt_q;
`else
    assign o_pulse_cnt = '0;
`endif

endmodule

// File: tb/tb_toggle_pulse_sync.sv
// Testbench for toggle_pulse_sync: directed phases with randomized spacing,
// checked against a pulse/count model of the toggle stream.
module tb_toggle_pulse_sync;

    localparam int S  = 2;
    localparam int WA = 8;
    localparam int WB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          src;
    logic          dst_a, lvl_a, dst_b, lvl_b;
    logic [WA-1:0] cnt_a;
    logic [WB-1:0] cnt_b;

    int n_vec = 0;
    int n_err = 0;

    int seen_a = 0;
    int seen_b = 0;

    // Model: every legal toggle is one pulse; counter = pulses since reset.
    int model_pulses = 0;
    int model_cnt    = 0;
    logic model_lvl  = 1'b0;

    toggle_pulse_sync #(.SYNC_STAGES(S), .CNT_W(WA)) dut_a (
        .i_dst_clk  (clk),
        .rst        (rst),
        .i_src_data (src),
        .o_dst_data (dst_a),
        .o_dst_level(lvl_a),
        .o_pulse_cnt(cnt_a)
    );

    toggle_pulse_sync #(.SYNC_STAGES(S), .CNT_W(WB)) dut_b (
        .i_dst_clk  (clk),
        .rst        (rst),
        .i_src_data (src),
        .o_dst_data (dst_b),
        .o_dst_level(lvl_b),
        .o_pulse_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dst_a === 1'b1) seen_a++;
        if (dst_b === 1'b1) seen_b++;
    end

    function automatic logic [31:0] exp_cnt(input int w);
`ifdef TOGGLE_SYNC_CNT_EN
        return 32'(model_cnt % (1 << w));
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_seen_a"}, seen_a, model_pulses);
        chk({tag, "_seen_b"}, seen_b, model_pulses);
        chk({tag, "_lvl_a"}, {31'd0, lvl_a}, {31'd0, model_lvl});
        chk({tag, "_lvl_b"}, {31'd0, lvl_b}, {31'd0, model_lvl});
        chk({tag, "_cnt_a"}, {24'd0, cnt_a}, exp_cnt(WA));
        chk({tag, "_cnt_b"}, {28'd0, cnt_b}, exp_cnt(WB));
    endtask

    // Input changes on the falling edge, so capture is deterministic:
    // the pulse is visible S+1 falling edges after the change.
    task automatic toggle_legal(input string tag, input int gap);
        int lat;
        bit found;
        src = ~src;
        model_lvl = src;
        model_pulses++;
        model_cnt++;
        lat = 0;
        found = 0;
        for (int k = 1; k <= S + 4; k++) begin
            @(negedge clk);
            if (!found && dst_a === 1'b1) begin
                found = 1;
                lat = k;
            end
        end
        chk({tag, "_latency"}, lat, S + 1);
        chk_state(tag);
        for (int k = S + 4; k < gap; k++) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        src = 1'b0;

        // Reset held, including source activity during reset.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_dst_a", {31'd0, dst_a}, 32'd0);
            chk("rst_cnt_a", {24'd0, cnt_a}, 32'd0);
        end
        src = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_tog_dst", {31'd0, dst_a}, 32'd0);
        chk("rst_tog_lvl", {31'd0, lvl_a}, 32'd0);
        src = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk_state("post_rst");

        // Single rising toggle.
        toggle_legal("single", 10);

        // Legal train of 10 toggles, 12 cycles apart.
        for (int i = 0; i < 10; i++) toggle_legal("train", 12);

        // Two flips inside one sampling window cancel.
        @(negedge clk);
        src = ~src;
        #2;
        src = ~src;
        repeat (12) @(negedge clk);
        chk_state("too_fast");

        // Random legal spacing.
        for (int i = 0; i < 12; i++) toggle_legal("rand", int'($urandom_range(6, 16)));

        // Mid-crossing reset: in-flight toggle is dropped, release with src=1.
        if (src) toggle_legal("pre_mid", 8);
        @(negedge clk);
        src = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        model_cnt = 0;
        #1;
        chk("mid_async_lvl", {31'd0, lvl_a}, 32'd0);
        chk("mid_async_cnt", {24'd0, cnt_a}, 32'd0);
        chk("mid_async_cntb", {28'd0, cnt_b}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_dst", {31'd0, dst_a}, 32'd0);
        end
        chk("mid_rst_seen", seen_a, model_pulses);
        rst = 1'b0;
        model_lvl = 1'b1;
        model_pulses++;
        model_cnt = 1;
        repeat (15) @(negedge clk);
        chk_state("mid_release");

        // 16 more toggles: 17 pulses since reset, 4-bit counter wraps to 1.
        for (int i = 0; i < 16; i++) toggle_legal("wrap", int'($urandom_range(6, 10)));
        chk("wrap_cnt_b", {28'd0, cnt_b}, exp_cnt(WB));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
